// File: rtl/reorder_buffer_pkg.sv
// Shared ROB / register-bus types and the ROB control state encoding.
// Imported by the reorder buffer and its rename table.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEF  = 16;
    localparam int ROB_ADDR_WIDTH = $clog2(ROB_DEPTH_DEF);
    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 32;

    typedef logic [ROB_ADDR_WIDTH-1:0] ROB_BUS;
    typedef logic [DATA_WIDTH_DEF-1:0] DATA_BUS;
    typedef logic [REG_ADDR_WIDTH-1:0] REG_ADDR_BUS;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REREF   = 2'd1,
        RESTORE = 2'd2
    } rob_state_e;

endpackage

// File: rtl/rob_rename_table.sv
// Per-architectural-register record of the youngest in-flight ROB id.
// One write (set or clear) per cycle, one combinational read.
module rob_rename_table
    import reorder_buffer_pkg::*;
#(
    parameter int ID_W = ROB_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic            i_set,
    input  REG_ADDR_BUS     i_waddr,
    input  logic [ID_W-1:0] i_wid,
    input  REG_ADDR_BUS     i_raddr,
    output logic [ID_W-1:0] o_rid,
    output logic            o_rvalid
);

    logic [ID_W-1:0]      r_last_id [REG_COUNT];
    logic [REG_COUNT-1:0] r_last_valid;

    // Valid bits: cleared on reset, set on rename, cleared on retire/restore
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_valid <= '0;
        end else if (i_we) begin
            r_last_valid[i_waddr] <= i_set;
        end
    end

    // Id storage only changes when a new rename is recorded
    always_ff @(posedge clk) begin
        if (i_we && i_set) begin
            r_last_id[i_waddr] <= i_wid;
        end
    end

    assign o_rid    = r_last_id[i_raddr];
    assign o_rvalid = r_last_valid[i_raddr];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer that owns the register-file write port:
// rename references on dispatch, values on commit, walk-restore on flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int ROB_DEPTH  = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = $clog2(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  REG_ADDR_BUS           alloc_dest,
    output logic                  alloc_ready,
    output logic [AW-1:0]         alloc_id,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_id,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  commit_valid,
    output logic [AW-1:0]         commit_id,
    output logic                  write_en,
    output REG_ADDR_BUS           write_addr,
    output logic                  write_restore,
    output logic                  write_is_ref,
    output logic [DATA_WIDTH-1:0] write_data
);

    localparam logic [AW:0] FULL = (AW+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]  r_valid;
    logic [ROB_DEPTH-1:0]  r_done;
    REG_ADDR_BUS           r_dest [ROB_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [ROB_DEPTH];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [AW:0]           r_count;
    rob_state_e            r_state;
    REG_ADDR_BUS           r_rst_cnt;
    REG_ADDR_BUS           r_reref_dest;

    REG_ADDR_BUS           w_head_dest;
    logic                  w_commit;
    logic                  w_cmt_port;
    logic                  w_grant;
    logic                  w_alloc_wr;
    logic                  w_match;
    REG_ADDR_BUS           w_raddr;
    logic [AW-1:0]         w_rid;
    logic                  w_rvalid;
    logic                  w_tw_en;
    logic                  w_tw_set;
    REG_ADDR_BUS           w_tw_addr;

    assign w_head_dest = r_dest[r_head];
    assign w_commit    = !rst && (r_state == RUN) && r_valid[r_head]
                         && r_done[r_head] && !flush;
    assign w_cmt_port  = w_commit && (w_head_dest != '0);
    assign w_match     = w_rvalid && (w_rid == r_head);

    assign alloc_ready = !rst && (r_state == RUN) && (r_count != FULL)
                         && !flush && !w_cmt_port;
    assign w_grant     = alloc_ready && alloc_valid;
    assign w_alloc_wr  = w_grant && (alloc_dest != '0);

    assign alloc_id     = rst ? '0 : r_tail;
    assign commit_valid = w_commit;
    assign commit_id    = w_commit ? r_head : '0;

    // Rename-table read address follows whichever phase needs it
    always_comb begin
        w_raddr = w_head_dest;
        if (r_state == RESTORE) begin
            w_raddr = r_rst_cnt;
        end else if (r_state == REREF) begin
            w_raddr = r_reref_dest;
        end
    end

    // Rename-table update: restore clear, retire clear, or new rename
    always_comb begin
        w_tw_en   = 1'b0;
        w_tw_set  = 1'b0;
        w_tw_addr = alloc_dest;
        if (!rst && !flush) begin
            if ((r_state == RESTORE) && w_rvalid) begin
                w_tw_en   = 1'b1;
                w_tw_addr = r_rst_cnt;
            end else if (w_cmt_port && w_match) begin
                w_tw_en   = 1'b1;
                w_tw_addr = w_head_dest;
            end else if (w_alloc_wr) begin
                w_tw_en   = 1'b1;
                w_tw_set  = 1'b1;
            end
        end
    end

    rob_rename_table #(
        .ID_W (AW)
    ) u_rename (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_tw_en),
        .i_set    (w_tw_set),
        .i_waddr  (w_tw_addr),
        .i_wid    (r_tail),
        .i_raddr  (w_raddr),
        .o_rid    (w_rid),
        .o_rvalid (w_rvalid)
    );

    // Register-file port arbitration: restore > reref > commit > alloc
    always_comb begin
        write_en      = 1'b0;
        write_addr    = '0;
        write_restore = 1'b0;
        write_is_ref  = 1'b0;
        write_data    = '0;
        if (!rst && !flush) begin
            if (r_state == RESTORE) begin
                if (w_rvalid) begin
                    write_en      = 1'b1;
                    write_restore = 1'b1;
                    write_addr    = r_rst_cnt;
                end
            end else if (r_state == REREF) begin
                write_en     = 1'b1;
                write_is_ref = 1'b1;
                write_addr   = r_reref_dest;
                write_data   = DATA_WIDTH'(w_rid);
            end else if (w_cmt_port) begin
                write_en   = 1'b1;
                write_addr = w_head_dest;
                write_data = r_data[r_head];
            end else if (w_alloc_wr) begin
                write_en     = 1'b1;
                write_is_ref = 1'b1;
                write_addr   = alloc_dest;
                write_data   = DATA_WIDTH'(r_tail);
            end
        end
    end

    // Entry valid/done tracking
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (wb_valid && r_valid[wb_id]) begin
                r_done[wb_id] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_grant) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
        end
    end

    // Entry payload: destination on grant, result on writeback
    always_ff @(posedge clk) begin
        if (!rst && !flush && wb_valid && r_valid[wb_id]) begin
            r_data[wb_id] <= wb_data;
        end
        if (w_grant) begin
            r_dest[r_tail] <= alloc_dest;
        end
    end

    // Head/tail pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_commit) begin
                r_head <= r_head + 1'b1;
            end
            if (w_grant) begin
                r_tail <= r_tail + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_grant) - (AW+1)'(w_commit);
        end
    end

    // Control FSM: run, one-cycle re-reference, flush restore walk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_rst_cnt    <= '0;
            r_reref_dest <= '0;
        end else if (flush) begin
            r_state   <= RESTORE;
            r_rst_cnt <= 5'd1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_cmt_port && w_rvalid && !w_match) begin
                        r_state      <= REREF;
                        r_reref_dest <= w_head_dest;
                    end
                end
                REREF: begin
                    r_state <= RUN;
                end
                RESTORE: begin
                    if (r_rst_cnt == 5'd31) begin
                        r_state   <= RUN;
                        r_rst_cnt <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

endmodule
